// File: rtl/ps2_key_decoder_if.sv
// PS/2 pin pair plus the decoded key levels and debug strobes.
// master = keyboard/bench side, slave = decoder side.
interface ps2_key_decoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic       key_left;
  logic       key_right;
  logic       key_down;
  logic       key_rotate_cw;
  logic       key_rotate_ccw;
  logic       key_drop;
  logic       key_hold;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       frame_err;

  modport master (
    output ps2_clk, ps2_data,
    input  key_left, key_right, key_down, key_rotate_cw, key_rotate_ccw,
           key_drop, key_hold, scan_code, scan_valid, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output key_left, key_right, key_down, key_rotate_cw, key_rotate_ccw,
           key_drop, key_hold, scan_code, scan_valid, frame_err
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver and Set 2 scan-code decoder. Conditions the raw
// pins, assembles 11-bit frames, and tracks make/break/extended prefixes to
// hold one level per game control.
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             rst,
  ps2_key_decoder_if.slave bus
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} dec_state_e;

  typedef struct packed {
    logic left;
    logic right;
    logic down;
    logic up;     // extended 75
    logic x;      // 22
    logic ccw;
    logic drop;
    logic hold;
  } keys_t;

  // ---------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------
  logic           clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic           filt_q, filt_prev_q;
  logic [FCW-1:0] filt_cnt_q;
  logic           fall;

  // Two-flop synchronizers; idle-high lines reset to 1 so reset is not a fall.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= bus.ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= bus.ps2_data;
      dat_s2_q <= dat_s1_q;
    end
  end

  // Glitch filter: follow the synchronized clock only after it has held a
  // new level for FILTER_LEN consecutive cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      filt_cnt_q  <= '0;
    end else begin
      filt_prev_q <= filt_q;
      if (clk_s2_q == filt_q) begin
        filt_cnt_q <= '0;
      end else if (filt_cnt_q == FCW'(FILTER_LEN - 1)) begin
        filt_q     <= clk_s2_q;
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + 1'b1;
      end
    end
  end

  assign fall = filt_prev_q & ~filt_q;

  // ---------------------------------------------------------------------
  // Frame receiver
  // ---------------------------------------------------------------------
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [9:0]     shift_q, shift_d;     // [0]=start, [8:1]=data, [9]=parity
  logic [TCW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]     scan_code_q, scan_code_d;
  logic           scan_valid_q, scan_valid_d;
  logic           frame_err_q, frame_err_d;

  // Next-state for bit assembly, frame checks and the partial-frame timeout.
  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    to_cnt_d     = to_cnt_q;
    scan_code_d  = scan_code_q;
    scan_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    if (fall) begin
      // A fall always wins over an expiring timeout.
      to_cnt_d = '0;
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = 4'd0;
        // Start low, odd parity over data+parity, stop (current bit) high.
        if (!shift_q[0] && (^shift_q[9:1]) && dat_s2_q) begin
          scan_code_d  = shift_q[8:1];
          scan_valid_d = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
      end else begin
        shift_d   = {dat_s2_q, shift_q[9:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (to_cnt_q == TCW'(TIMEOUT_CYCLES - 1)) begin
        bit_cnt_d   = 4'd0;
        to_cnt_d    = '0;
        frame_err_d = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  // Receiver registers.
  // NOTE: the shift register is reset too; it is tiny and a clean start
  // keeps the first frame after reset independent of stale bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q    <= 4'd0;
      shift_q      <= '0;
      to_cnt_q     <= '0;
      scan_code_q  <= 8'h00;
      scan_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      to_cnt_q     <= to_cnt_d;
      scan_code_q  <= scan_code_d;
      scan_valid_q <= scan_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // ---------------------------------------------------------------------
  // Prefix decoder and key latches
  // ---------------------------------------------------------------------
  dec_state_e state_q, state_d;
  keys_t      keys_q, keys_d;
  logic       apply, ext_sel, level;

  // Prefix tracking; a completed code sets (make) or clears (break) one key.
  always_comb begin
    state_d = state_q;
    keys_d  = keys_q;
    apply   = 1'b0;
    ext_sel = 1'b0;
    level   = 1'b0;
    if (scan_valid_q) begin
      case (state_q)
        IDLE: begin
          if (scan_code_q == CODE_EXT)      state_d = EXT;
          else if (scan_code_q == CODE_BRK) state_d = BRK;
          else begin
            apply = 1'b1;
            level = 1'b1;
          end
        end
        EXT: begin
          if (scan_code_q == CODE_BRK) state_d = EXT_BRK;
          else begin
            apply   = 1'b1;
            ext_sel = 1'b1;
            level   = 1'b1;
            state_d = IDLE;
          end
        end
        BRK: begin
          apply   = 1'b1;
          state_d = IDLE;
        end
        EXT_BRK: begin
          apply   = 1'b1;
          ext_sel = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    if (apply) begin
      if (ext_sel) begin
        case (scan_code_q)
          8'h6B:   keys_d.left  = level;
          8'h74:   keys_d.right = level;
          8'h72:   keys_d.down  = level;
          8'h75:   keys_d.up    = level;
          default: ;
        endcase
      end else begin
        case (scan_code_q)
          8'h22:   keys_d.x    = level;
          8'h1A:   keys_d.ccw  = level;
          8'h29:   keys_d.drop = level;
          8'h21:   keys_d.hold = level;
          default: ;
        endcase
      end
    end
  end

  // Decoder state and key latch registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      keys_q  <= '0;
    end else begin
      state_q <= state_d;
      keys_q  <= keys_d;
    end
  end

  assign bus.key_left       = keys_q.left;
  assign bus.key_right      = keys_q.right;
  assign bus.key_down       = keys_q.down;
  assign bus.key_rotate_cw  = keys_q.up | keys_q.x;
  assign bus.key_rotate_ccw = keys_q.ccw;
  assign bus.key_drop       = keys_q.drop;
  assign bus.key_hold       = keys_q.hold;
  assign bus.scan_code      = scan_code_q;
  assign bus.scan_valid     = scan_valid_q;
  assign bus.frame_err      = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed frame table, multi-cycle corner
// sequences, then random frames checked against a held-key model.
module tb_ps2_key_decoder;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 300;
  localparam int HALF       = 20;               // PS/2 half period in clk cycles
  localparam int LAT_LO     = FILTER_LEN + 3;   // negedges from pin fall to scan_valid
  localparam int LAT_HI     = FILTER_LEN + 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ps2_key_decoder_if bus ();

  ps2_key_decoder #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Key vector order: {left, right, down, rotate_cw, rotate_ccw, drop, hold}
  function automatic logic [6:0] keys_now();
    return {bus.key_left, bus.key_right, bus.key_down, bus.key_rotate_cw,
            bus.key_rotate_ccw, bus.key_drop, bus.key_hold};
  endfunction

  // Reference model: set of held codes per table, plus pending prefixes.
  bit held [2][256];
  bit m_ext, m_brk;

  function automatic void model_reset();
    for (int t = 0; t < 2; t++)
      for (int c = 0; c < 256; c++) held[t][c] = 1'b0;
    m_ext = 1'b0;
    m_brk = 1'b0;
  endfunction

  function automatic void model_byte(input logic [7:0] c);
    if (m_brk) begin
      held[m_ext][c] = 1'b0;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (c == 8'hF0) begin
      m_brk = 1'b1;
    end else if (c == 8'hE0 && !m_ext) begin
      m_ext = 1'b1;
    end else begin
      held[m_ext][c] = 1'b1;
      m_ext = 1'b0;
    end
  endfunction

  function automatic logic [6:0] model_keys();
    return {held[1][8'h6B], held[1][8'h74], held[1][8'h72],
            held[1][8'h75] | held[0][8'h22], held[0][8'h1A],
            held[0][8'h29], held[0][8'h21]};
  endfunction

  logic [6:0] cur_keys;   // keys the bench expects right now

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.ps2_data = b;
    tick(HALF);
    bus.ps2_clk = 1'b0;
    tick(HALF);
    bus.ps2_clk = 1'b1;
  endtask

  // bad: 0 good, 1 parity flipped, 2 stop low, 3 start high
  task automatic send_frame(input string name, input logic [7:0] c, input int bad,
                            input logic [6:0] exp_keys);
    logic [9:0] bits;
    int n;
    bits = {~(^c) ^ (bad == 1), c, (bad == 3)};
    for (int i = 0; i < 10; i++) send_bit(bits[i]);
    bus.ps2_data = (bad != 2);
    tick(HALF);
    bus.ps2_clk = 1'b0;
    n = 0;
    while (n < HALF) begin
      @(negedge clk);
      n++;
      if (bus.scan_valid || bus.frame_err) break;
    end
    check({name, ".latency_ok"}, (n >= LAT_LO && n <= LAT_HI), 1);
    if (bad == 0) begin
      check({name, ".valid"}, bus.scan_valid, 1);
      check({name, ".err"}, bus.frame_err, 0);
      check({name, ".code"}, bus.scan_code, c);
    end else begin
      check({name, ".err"}, bus.frame_err, 1);
      check({name, ".valid"}, bus.scan_valid, 0);
    end
    check({name, ".keys_f1"}, keys_now(), cur_keys);
    @(negedge clk);
    check({name, ".pulse_end"}, {bus.scan_valid, bus.frame_err}, 0);
    check({name, ".keys_f2"}, keys_now(), exp_keys);
    cur_keys = exp_keys;
    @(posedge clk);
    #1;
    tick(HALF);
    bus.ps2_clk = 1'b1;
    tick(2 * HALF);
  endtask

  typedef struct {
    logic [7:0] code;
    int         bad;
    logic [6:0] keys;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int errs, vals;
    logic [7:0] pool [13];
    logic [7:0] c;
    int bad;

    pool = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h72, 8'h75, 8'h22,
             8'h1A, 8'h29, 8'h21, 8'hE1, 8'hFA, 8'hAA};

    // Directed table: expected key vectors derived by hand.
    vecs.push_back('{8'h1A, 0, 7'h04});  // Z make
    vecs.push_back('{8'hF0, 0, 7'h04});
    vecs.push_back('{8'h1A, 0, 7'h00});  // Z break
    vecs.push_back('{8'hE0, 0, 7'h00});
    vecs.push_back('{8'h6B, 0, 7'h40});  // ext left make
    vecs.push_back('{8'h6B, 0, 7'h40});  // keypad 4: no key
    vecs.push_back('{8'hE0, 0, 7'h40});
    vecs.push_back('{8'hF0, 0, 7'h40});
    vecs.push_back('{8'h6B, 0, 7'h00});  // ext left break
    vecs.push_back('{8'hE0, 0, 7'h00});
    vecs.push_back('{8'h75, 0, 7'h08});  // up make
    vecs.push_back('{8'h22, 0, 7'h08});  // X make
    vecs.push_back('{8'hE0, 0, 7'h08});
    vecs.push_back('{8'hF0, 0, 7'h08});
    vecs.push_back('{8'h75, 0, 7'h08});  // up break, X still held
    vecs.push_back('{8'hF0, 0, 7'h08});
    vecs.push_back('{8'h22, 0, 7'h00});  // X break
    vecs.push_back('{8'h29, 1, 7'h00});  // parity error
    vecs.push_back('{8'h29, 0, 7'h02});  // space make
    vecs.push_back('{8'h29, 0, 7'h02});  // typematic repeat
    vecs.push_back('{8'hE0, 0, 7'h02});
    vecs.push_back('{8'h72, 0, 7'h12});  // ext down make
    vecs.push_back('{8'hE1, 0, 7'h12});
    vecs.push_back('{8'hFA, 0, 7'h12});
    vecs.push_back('{8'hF0, 0, 7'h12});
    vecs.push_back('{8'h29, 0, 7'h10});  // space break
    vecs.push_back('{8'h21, 2, 7'h10});  // bad stop
    vecs.push_back('{8'h21, 3, 7'h10});  // bad start

    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    model_reset();
    cur_keys = 7'h00;
    tick(5);
    check("reset.in_reset", {keys_now(), bus.scan_code, bus.scan_valid, bus.frame_err}, 0);
    rst = 1'b0;
    tick(5);
    check("reset.keys", keys_now(), 0);
    check("reset.code", bus.scan_code, 0);
    check("reset.strobes", {bus.scan_valid, bus.frame_err}, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      send_frame($sformatf("vec%0d", i), vecs[i].code, vecs[i].bad, vecs[i].keys);
      if (vecs[i].bad == 0) model_byte(vecs[i].code);
    end

    // Partial frame abandoned by timeout: exactly one error, no byte.
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    errs = 0;
    vals = 0;
    for (int i = 0; i < TIMEOUT + 60; i++) begin
      @(negedge clk);
      if (bus.frame_err)  errs++;
      if (bus.scan_valid) vals++;
    end
    tick(1);
    check("timeout.err_count", errs, 1);
    check("timeout.no_valid", vals, 0);
    check("timeout.keys", keys_now(), cur_keys);
    send_frame("after_timeout", 8'h21, 0, 7'h11);
    model_byte(8'h21);

    // Short glitch on ps2_clk must not register as a bit.
    bus.ps2_clk = 1'b0;
    tick(3);
    bus.ps2_clk = 1'b1;
    errs = 0;
    vals = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.frame_err || bus.scan_valid) errs++;
    end
    tick(1);
    check("glitch.no_pulse", errs, 0);
    send_frame("after_glitch", 8'hE0, 0, 7'h11);
    model_byte(8'hE0);
    send_frame("after_glitch2", 8'h74, 0, 7'h31);
    model_byte(8'h74);

    // Asynchronous reset mid-frame while down is held.
    check("pre_rst.down", bus.key_down, 1);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst.outputs", {keys_now(), bus.scan_code, bus.scan_valid, bus.frame_err}, 0);
    bus.ps2_data = 1'b1;
    tick(3);
    rst = 1'b0;
    model_reset();
    cur_keys = 7'h00;
    tick(5);
    send_frame("after_rst", 8'h1A, 0, 7'h04);
    model_byte(8'h1A);

    // Random frames against the model.
    for (int i = 0; i < 40; i++) begin
      c = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : pool[$urandom_range(0, 12)];
      bad = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      if (bad == 0) model_byte(c);
      send_frame($sformatf("rnd%0d_%02h", i, c), c, bad, model_keys());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Receives raw PS/2 keyboard clock and data and turns them into one held/not-held level per game control. It decodes make, break and extended scan codes (Set 2). It sits between the board PS/2 pins and `input_manager`, and its `key_*` outputs drive that block's `raw_*` inputs directly. It performs no edge detection and no auto-repeat; those stay downstream.

## Interface
- `FILTER_LEN`, 8: consecutive identical synchronized samples required before the filtered PS/2 clock changes level.
- `TIMEOUT_CYCLES`, 100000: idle `clk` cycles after which a partial frame is abandoned (1 ms at 100 MHz).
- `clk` input 1: system clock, single clock domain.
- `rst` input 1: asynchronous, active-high reset.
- `ps2_clk` input 1: raw PS/2 clock pin, asynchronous to `clk`.
- `ps2_data` input 1: raw PS/2 data pin, asynchronous to `clk`.
- `key_left` output 1: level, held while E0 6B is down.
- `key_right` output 1: level, held while E0 74 is down.
- `key_down` output 1: level, held while E0 72 is down.
- `key_rotate_cw` output 1: level, held while E0 75 (Up) or 22 (X) is down.
- `key_rotate_ccw` output 1: level, held while 1A (Z) is down.
- `key_drop` output 1: level, held while 29 (Space) is down.
- `key_hold` output 1: level, held while 21 (C) is down.
- `scan_code` output 8: last valid received byte, for debug.
- `scan_valid` output 1: one-cycle pulse when `scan_code` updates.
- `frame_err` output 1: one-cycle pulse on a bad start, parity or stop bit, or on a timeout.

## Operation
**Input conditioning**
- `ps2_clk` and `ps2_data` each pass through a 2-flop synchronizer.
- The filtered clock takes the synchronized clock's value once that value has been identical for `FILTER_LEN` consecutive cycles. It resets to 1.
- `fall` pulses for one cycle when the filtered clock goes 1→0. The synchronized data is sampled on `fall`.

**Frame receiver**
- Uses a 4-bit bit counter, 0..10. Bits arrive in order: start (must be 0), 8 data bits LSB first, odd parity, stop (must be 1).
- On the 11th `fall`, all three checks are evaluated:
  - All pass: load `scan_code` and pulse `scan_valid`.
  - Any fails: pulse `frame_err` and discard the byte.
- The bit counter returns to 0 in either case.
- A timeout counter clears on every `fall` and counts while the bit counter is nonzero. When it reaches `TIMEOUT_CYCLES`, the bit counter goes to 0 and `frame_err` pulses. No byte is emitted.

**Decoder FSM**
- States: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 then F0).
- IDLE:
  - E0 → EXT.
  - F0 → BRK.
  - Any other byte is a make code: set the mapped non-extended key and stay in IDLE.
- EXT:
  - F0 → EXT_BRK.
  - Any other byte: set the mapped extended key, → IDLE.
- BRK: clear the mapped non-extended key, → IDLE.
- EXT_BRK: clear the mapped extended key, → IDLE.
- Unmapped codes change no key but still perform the state transition.
- E1, FA and AA are treated as ordinary unmapped bytes.
- Extended and non-extended tables are distinct. For example, non-extended 6B (keypad 4) must not assert `key_left`.
- `key_rotate_cw` is the OR of two internal latches, `up_held` and `x_held`. Releasing one key while the other is still held keeps the output at 1.
- Repeated make codes (typematic) re-set an already-set key, so the output stays 1 with no glitch.
- `frame_err` does not change the FSM state or any key state.

## Timing
- Reset values:
  - All `key_*` outputs: 0.
  - `scan_code`: 00.
  - `scan_valid`, `frame_err`: 0.
  - FSM: IDLE.
  - Counters: 0.
  - Filtered clock and synchronizers: 1.
- Latency is measured from cycle F, the cycle in which `fall` is high for the stop bit:
  - `scan_valid` and `scan_code` are updated at F+1.
  - `key_*` outputs change at F+2.
- From a raw pin edge, `fall` occurs 2 + `FILTER_LEN` cycles later, ±1 cycle.
- Glitches on `ps2_clk` shorter than `FILTER_LEN` cycles produce no `fall`.
- Asynchronous reset asserted mid-frame or mid-prefix clears everything immediately, with no partial byte. The first frame after release decodes normally.
- A timeout and a `fall` in the same cycle: the `fall` wins, the counter clears and no error is raised.

## Test plan
- Make frame for 1A (bits 0,0,1,0,1,1,0,0,0, parity 0, stop 1), 40 µs half-period → `scan_code`=1A and `scan_valid` 1 cycle at F+1; `key_rotate_ccw`=1 at F+2. Then send F0, 1A → `key_rotate_ccw`=0 two cycles after the second stop bit.
- Send E0 6B → `key_left`=1. Send 6B alone → no change to any key. Send E0 F0 6B → `key_left`=0. FSM returns to IDLE after each sequence.
- Press E0 75, then 22, then release E0 75 → `key_rotate_cw` stays 1. Then release 22 → `key_rotate_cw`=0.
- Parity bit flipped on byte 29 → `frame_err` pulses, no `scan_valid`, `key_drop` stays 0. A correct 29 afterwards → `key_drop`=1.
- Stop after 5 bits and idle `TIMEOUT_CYCLES` → `frame_err` pulses once. The next full frame of 21 → `key_hold`=1.
- 3-cycle low glitch on `ps2_clk` → no `fall`. Assert `rst` mid-frame while `key_down`=1 → all outputs 0 asynchronously.
